program_memory_loader: RTL

- Parametrised, writable successor to the fixed-image program ROM.
- Holds the CPU program in a DEPTH x DATA_WIDTH array with a combinational read port on the CPU side.
- Adds a streamed loader (valid/ready) that writes a length-prefixed, checksummed image from address 0.
- Fills unused addresses with FILL_WORD. Flags success or failure to the host/UART bridge.

---
 rtl/program_memory_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/program_memory_loader.sv
// Writable program memory for the CPU fetch port, loaded from a streamed,
// length-prefixed, checksummed image. Addresses not covered by the image
// are filled with FILL_WORD (NOP). While a load runs, the CPU sees FILL_WORD.
module program_memory_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 8'h70
) (
  input  logic                  program_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_bus,
  output logic [DATA_WIDTH-1:0] data_bus,
  input  logic                  load_start,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_FILL,
    S_DONE
  } state_t;

  // Word counter increments but never passes DEPTH.
  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v == DEPTH_CNT) ? v : v + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  err_pend_q;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [DATA_WIDTH-1:0] sum_d;
  logic [ADDR_WIDTH:0]   count_d;
  logic [ADDR_WIDTH:0]   len_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Stream handshake and next-value arithmetic for the loader registers.
  always_comb begin
    load_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    xfer       = load_valid && load_ready;
    ptr_d      = ptr_q + 1'b1;
    sum_d      = sum_q + load_data;
    count_d    = sat_inc(count_q);
    // A length field of zero encodes a full-depth image.
    len_d      = (load_data[ADDR_WIDTH-1:0] == '0) ? DEPTH_CNT
                                                   : {1'b0, load_data[ADDR_WIDTH-1:0]};
    // No memory write on a reset edge, so an aborted load keeps exactly
    // the words accepted before the reset.
    mem_we     = reset && (((state_q == S_DATA) && xfer) || (state_q == S_FILL));
    mem_wdata  = (state_q == S_FILL) ? FILL_WORD : load_data;
  end

  // Single write port shared by image data and fill words; contents survive reset.
  always_ff @(posedge program_clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  // Loader FSM with registered busy/done/error/count outputs.
  always_ff @(posedge program_clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sum_q      <= '0;
      n_q        <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LEN;
            ptr_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer) begin
            n_q     <= len_d;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            if (count_d == n_q) begin
              state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            err_pend_q <= (load_data != sum_q);
            // Full-depth image: pointer already wrapped, nothing to fill.
            if (n_q == DEPTH_CNT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= (load_data != sum_q);
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          ptr_q <= ptr_d;
          if (ptr_q == '1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= err_pend_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign load_count = count_q;
  assign data_bus   = busy_q ? FILL_WORD : mem_q[address_bus];

endmodule
